// File: rtl/rvga_line_fill_pkg.sv
// Shared types for the rvga line-fill initiator: FSM state encoding and word size.
package rvga_line_fill_pkg;

  typedef enum logic [1:0] {
    e_fill_idle,
    e_fill_wb,
    e_fill_fill,
    e_fill_done
  } rvga_fill_state_e;

  localparam int rvga_word_bytes_gp = 4;

endpackage

// File: rtl/rvga_line_fill.sv
// Cache-miss engine on the rvga word interface: optional victim writeback, then a
// one-word-per-transfer fill of the missing line, finished by a one-cycle done pulse.
module rvga_line_fill
  import rvga_line_fill_pkg::*;
#(
  parameter int words_per_line_p = 4,
  parameter int debug_p          = 0
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            start_v_i,
  input  logic                            wb_en_i,
  input  logic [31:0]                     fill_addr_i,
  input  logic [31:0]                     victim_addr_i,
  input  logic [32*words_per_line_p-1:0]  victim_line_i,
  output logic                            ready_o,
  output logic                            done_v_o,
  output logic [32*words_per_line_p-1:0]  line_o,
  output logic                            r_v_o,
  output logic                            w_v_o,
  output logic [31:0]                     addr_o,
  output logic [31:0]                     data_o,
  input  logic [31:0]                     data_i,
  input  logic                            resp_v_i
);

  localparam int cnt_w_lp = $clog2(words_per_line_p);
  localparam int line_w_lp = 32 * words_per_line_p;
  localparam logic [31:0] base_mask_lp =
    ~(32'(rvga_word_bytes_gp * words_per_line_p) - 32'd1);
  localparam logic [cnt_w_lp-1:0] last_cnt_lp = cnt_w_lp'(words_per_line_p - 1);

  // Tracing is a simulation-only wrapper concern; here we only reject bad values.
  if (words_per_line_p < 2 || (words_per_line_p & (words_per_line_p - 1)) != 0 ||
      debug_p < 0 || debug_p > 1) begin : g_bad_params
    $error("rvga_line_fill: unsupported parameter values");
  end

  rvga_fill_state_e      state_r;
  logic [cnt_w_lp-1:0]   cnt_r;
  logic [31:0]           fbase_r;
  logic [31:0]           vbase_r;
  logic [line_w_lp-1:0]  victim_r;
  logic [line_w_lp-1:0]  line_r;

  logic                  last_word;
  logic [31:0]           word_off;
  logic [31:0]           victim_word;

  assign last_word   = (cnt_r == last_cnt_lp);
  assign word_off    = 32'({cnt_r, 2'b00});
  assign victim_word = victim_r[32*cnt_r +: 32];

  // Request lines decode only registered state so a same-cycle responder cannot loop back.
  always_comb begin
    r_v_o  = 1'b0;
    w_v_o  = 1'b0;
    addr_o = '0;
    data_o = '0;
    case (state_r)
      e_fill_wb: begin
        w_v_o  = 1'b1;
        addr_o = vbase_r | word_off;
        data_o = victim_word;
      end
      e_fill_fill: begin
        r_v_o  = 1'b1;
        addr_o = fbase_r | word_off;
      end
      default: ;
    endcase
  end

  assign ready_o  = (state_r == e_fill_idle);
  assign done_v_o = (state_r == e_fill_done);
  assign line_o   = line_r;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r  <= e_fill_idle;
      cnt_r    <= '0;
      fbase_r  <= '0;
      vbase_r  <= '0;
      victim_r <= '0;
      line_r   <= '0;
    end else begin
      case (state_r)
        e_fill_idle: begin
          if (start_v_i) begin
            fbase_r  <= fill_addr_i & base_mask_lp;
            vbase_r  <= victim_addr_i & base_mask_lp;
            victim_r <= victim_line_i;
            cnt_r    <= '0;
            state_r  <= wb_en_i ? e_fill_wb : e_fill_fill;
          end
        end
        e_fill_wb: begin
          if (resp_v_i) begin
            if (last_word) begin
              cnt_r   <= '0;
              state_r <= e_fill_fill;
            end else begin
              cnt_r <= cnt_r + cnt_w_lp'(1);
            end
          end
        end
        e_fill_fill: begin
          if (resp_v_i) begin
            line_r[32*cnt_r +: 32] <= data_i;
            if (last_word) begin
              cnt_r   <= '0;
              state_r <= e_fill_done;
            end else begin
              cnt_r <= cnt_r + cnt_w_lp'(1);
            end
          end
        end
        default: begin
          state_r <= e_fill_idle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rvga_line_fill.sv
// Randomized bench for rvga_line_fill: a word-memory responder plus a transfer-list
// model of each miss, compared against the DUT on every cycle.
module tb_rvga_line_fill;

  localparam int N  = 4;
  localparam int LW = 32 * N;

  logic            clk = 1'b0;
  logic            rst_i;
  logic            start_v_i;
  logic            wb_en_i;
  logic [31:0]     fill_addr_i;
  logic [31:0]     victim_addr_i;
  logic [LW-1:0]   victim_line_i;
  logic            ready_o;
  logic            done_v_o;
  logic [LW-1:0]   line_o;
  logic            r_v_o;
  logic            w_v_o;
  logic [31:0]     addr_o;
  logic [31:0]     data_o;
  logic [31:0]     data_i;
  logic            resp_v_i;

  always #5 clk = ~clk;

  rvga_line_fill #(.words_per_line_p(N), .debug_p(0)) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .start_v_i(start_v_i),
    .wb_en_i(wb_en_i),
    .fill_addr_i(fill_addr_i),
    .victim_addr_i(victim_addr_i),
    .victim_line_i(victim_line_i),
    .ready_o(ready_o),
    .done_v_o(done_v_o),
    .line_o(line_o),
    .r_v_o(r_v_o),
    .w_v_o(w_v_o),
    .addr_o(addr_o),
    .data_o(data_o),
    .data_i(data_i),
    .resp_v_i(resp_v_i)
  );

  // Responder memory: identity-initialised 4 KB window; request held until wait_cnt reaches cur_delay.
  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];
  int  wait_cnt  = 0;
  int  cur_delay = 0;
  int  delay_cfg = 0;
  bit  rand_en   = 1'b0;
  logic req;

  assign req      = r_v_o | w_v_o;
  assign resp_v_i = req && (wait_cnt >= cur_delay);
  assign data_i   = mem[addr_o[11:2]];

  always @(posedge clk) begin
    if (w_v_o && resp_v_i) mem[addr_o[11:2]] <= data_o;
    if (rst_i || !req || resp_v_i) begin
      wait_cnt  <= 0;
      cur_delay <= rand_en ? int'($urandom_range(0, 3)) : delay_cfg;
    end else begin
      wait_cnt <= wait_cnt + 1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Behavioural model: each miss becomes a list of expected transfers.
  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    int          word;
  } xfer_t;

  xfer_t       q[$];
  int          phase = 0;
  logic [LW-1:0] m_line = '0;
  int          acc_cyc = 0;
  int          last_lat = 0;
  int          done_count = 0;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic modelAccept();
    logic [31:0] fb, vb, a;
    fb = fill_addr_i & ~32'(4*N - 1);
    vb = victim_addr_i & ~32'(4*N - 1);
    if (wb_en_i) begin
      for (int k = 0; k < N; k++) begin
        a = vb + 32'(4*k);
        ref_mem[a[11:2]] = victim_line_i[32*k +: 32];
        q.push_back('{wr: 1'b1, addr: a, data: victim_line_i[32*k +: 32], word: k});
      end
    end
    for (int k = 0; k < N; k++) begin
      a = fb + 32'(4*k);
      q.push_back('{wr: 1'b0, addr: a, data: ref_mem[a[11:2]], word: k});
    end
    acc_cyc = cyc;
    phase = 1;
  endtask

  always @(negedge clk) begin
    if (rst_i) begin
      chk("rst_ready", ready_o, 1);
      chk("rst_done", done_v_o, 0);
      chk("rst_r_v", r_v_o, 0);
      chk("rst_w_v", w_v_o, 0);
      chk("rst_addr", addr_o, 0);
      chk("rst_data", data_o, 0);
      chk("rst_line", line_o, 0);
      phase = 0;
      q.delete();
      m_line = '0;
    end else begin
      chk("ready", ready_o, phase == 0);
      chk("done", done_v_o, phase == 2);
      chk("line", line_o, m_line);
      if (phase == 1) begin
        chk("r_v", r_v_o, !q[0].wr);
        chk("w_v", w_v_o, q[0].wr);
        chk("addr", addr_o, q[0].addr);
        if (q[0].wr) chk("wdata", data_o, q[0].data);
        if (resp_v_i) begin
          if (!q[0].wr) m_line[32*q[0].word +: 32] = q[0].data;
          void'(q.pop_front());
          if (q.size() == 0) phase = 2;
        end
      end else begin
        chk("idle_r_v", r_v_o, 0);
        chk("idle_w_v", w_v_o, 0);
        chk("idle_addr", addr_o, 0);
        chk("idle_data", data_o, 0);
        if (phase == 2) begin
          done_count++;
          last_lat = cyc - acc_cyc;
          phase = 0;
        end else if (start_v_i) begin
          modelAccept();
        end
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] fa, input bit wb, input logic [31:0] va,
                               input logic [LW-1:0] vl);
    @(posedge clk); #1;
    fill_addr_i   = fa;
    wb_en_i       = wb;
    victim_addr_i = va;
    victim_line_i = vl;
    start_v_i     = 1'b1;
    @(posedge clk); #1;
    start_v_i     = 1'b0;
    fill_addr_i   = $urandom & 32'hFFF;
    victim_addr_i = $urandom & 32'hFFF;
    wb_en_i       = 1'($urandom);
    victim_line_i = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic waitDone(input int budget);
    int n = 0;
    while (!done_v_o && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (!done_v_o) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL done_timeout: got no done_v_o within %0d cycles", budget);
    end
    @(negedge clk); #1;
  endtask

  task automatic checkOutput(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    chk(name, act, exp);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int d0;
    logic [LW-1:0] vl2;
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = 32'(i * 4);
      ref_mem[i] = 32'(i * 4);
    end
    rst_i = 1'b1;
    start_v_i = 1'b0;
    wb_en_i = 1'b0;
    fill_addr_i = '0;
    victim_addr_i = '0;
    victim_line_i = '0;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;

    $display("[TB] case 1: plain fill of 0x104");
    applyStimulus(32'h104, 1'b0, 32'h0, '0);
    waitDone(50);
    checkOutput("case1_line", line_o, 128'h0000010C_00000108_00000104_00000100);
    checkOutput("case1_latency", last_lat, 5);

    $display("[TB] case 2: writeback 0x200 then fill 0x300");
    vl2 = 128'hDDDD0004_CCCC0003_BBBB0002_AAAA0001;
    applyStimulus(32'h300, 1'b1, 32'h200, vl2);
    waitDone(50);
    checkOutput("case2_line", line_o, 128'h0000030C_00000308_00000304_00000300);
    checkOutput("case2_latency", last_lat, 9);
    checkOutput("case2_readback", mem[32'h204 >> 2], 32'hBBBB0002);

    $display("[TB] case 3: responder delayed 3 cycles");
    delay_cfg = 3;
    applyStimulus(32'h10C, 1'b0, 32'h0, '0);
    waitDone(100);
    checkOutput("case3_line", line_o, 128'h0000010C_00000108_00000104_00000100);
    checkOutput("case3_latency", last_lat, 17);
    delay_cfg = 0;

    $display("[TB] case 4: start pulse during fill is dropped");
    applyStimulus(32'h400, 1'b0, 32'h0, '0);
    checkOutput("case4_ready_busy", ready_o, 0);
    fill_addr_i = 32'h800;
    start_v_i = 1'b1;
    @(posedge clk); #1;
    start_v_i = 1'b0;
    waitDone(50);
    checkOutput("case4_line", line_o, 128'h0000040C_00000408_00000404_00000400);
    checkOutput("case4_latency", last_lat, 5);
    repeat (3) @(posedge clk);
    #1 checkOutput("case4_no_extra", r_v_o, 0);

    $display("[TB] case 5: reset mid-fill");
    applyStimulus(32'h600, 1'b0, 32'h0, '0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("case5_partial", line_o, 128'h0000040C_00000408_00000604_00000600);
    rst_i = 1'b1;
    #1;
    checkOutput("case5_r_v", r_v_o, 0);
    checkOutput("case5_ready", ready_o, 1);
    checkOutput("case5_line", line_o, 0);
    @(posedge clk); #1 rst_i = 1'b0;
    applyStimulus(32'h100, 1'b0, 32'h0, '0);
    waitDone(50);
    checkOutput("case5_restart_line", line_o, 128'h0000010C_00000108_00000104_00000100);

    $display("[TB] case 6: back-to-back misses with start held");
    d0 = done_count;
    @(posedge clk); #1;
    fill_addr_i = 32'h700;
    wb_en_i = 1'b1;
    victim_addr_i = 32'h780;
    victim_line_i = {$urandom, $urandom, $urandom, $urandom};
    start_v_i = 1'b1;
    repeat (20) @(posedge clk);
    #1 start_v_i = 1'b0;
    repeat (4) @(posedge clk);
    #1 checkOutput("case6_done_count", done_count - d0, 2);

    $display("[TB] random misses");
    rand_en = 1'b1;
    for (int it = 0; it < 30; it++) begin
      applyStimulus($urandom & 32'hFFF, 1'($urandom), $urandom & 32'hFFF,
                    {$urandom, $urandom, $urandom, $urandom});
      if ($urandom_range(0, 1) == 1) begin
        start_v_i = 1'b1;
        @(posedge clk); #1;
        start_v_i = 1'b0;
      end
      waitDone(200);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    rand_en = 1'b0;
    repeat (4) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
